ddr2_cmd_arbiter: RTL and testbench

Parametrised DDR2 command-bus arbiter that sits between the init sequencer, the auto-refresh engine and NUM_CH-1 further command sources (write/read engines) and the DDR2 pins. The init path owns the bus after reset until init completes. After that the block grants the bus to one channel at a time: refresh (channel 0) has fixed top priority, and the remaining channels share round-robin. The selected command, bank and address are driven out registered, with NOP whenever no channel holds the bus.

---
 rtl/ddr2_pkg.sv | 23 ++
 rtl/ddr2_rr_pick.sv | 36 +++
 rtl/ddr2_cmd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ddr2_cmd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// DDR2 command encodings and default bus widths shared by the
// init sequencer, refresh engine, data engines and the bus arbiter.
package ddr2_pkg;

    localparam int DDR2_ADDR_BITS = 13;
    localparam int DDR2_BA_BITS   = 3;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

endpackage

// File: rtl/ddr2_rr_pick.sv
// Round-robin pick among the data-engine channels 1..NUM_CH-1,
// starting the scan at rr_ptr and wrapping back to channel 1.
module ddr2_rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:1] req,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_CH-1:1] pick,
    output logic              valid
);

    function automatic int slot(input logic [PTR_W-1:0] p,
                                input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_CH) begin
            s = s - (NUM_CH - 1);
        end
        return s;
    endfunction

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int off = 0; off < NUM_CH - 1; off++) begin
            for (int i = 1; i < NUM_CH; i++) begin
                if (!valid && req[i] && slot(rr_ptr, off) == i) begin
                    pick[i] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// DDR2 command-bus arbiter: init owns the bus until init_end, then
// refresh (ch0) has fixed priority and ch1.. share round-robin.
module ddr2_cmd_arbiter
    import ddr2_pkg::*;
#(
    parameter int ADDR_BITS = DDR2_ADDR_BITS,
    parameter int BA_BITS   = DDR2_BA_BITS,
    parameter int NUM_CH    = 4,
    parameter int HOLD_MAX  = 1024
) (
    input  logic                        ck,
    input  logic                        rst_n,
    input  logic                        init_cke,
    input  logic [3:0]                  init_cmd,
    input  logic [BA_BITS-1:0]          init_ba,
    input  logic [ADDR_BITS-1:0]        init_addr,
    input  logic                        init_end,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic [NUM_CH-1:0]           ch_end,
    input  logic [4*NUM_CH-1:0]         ch_cmd,
    input  logic [BA_BITS*NUM_CH-1:0]   ch_ba,
    input  logic [ADDR_BITS*NUM_CH-1:0] ch_addr,
    output logic [NUM_CH-1:0]           ch_gnt,
    output logic                        ddr2_cke,
    output logic                        ddr2_cs_n,
    output logic                        ddr2_ras_n,
    output logic                        ddr2_cas_n,
    output logic                        ddr2_we_n,
    output logic [BA_BITS-1:0]          ddr2_ba,
    output logic [ADDR_BITS-1:0]        ddr2_addr,
    output logic                        err_hold
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_ERR   = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(HOLD_MAX);

    arb_state_t            state_q, state_d;
    logic [NUM_CH-1:0]     gnt_q, gnt_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [BA_BITS-1:0]    ba_q, ba_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  cke_q, cke_d;
    logic                  err_q, err_d;

    logic [NUM_CH-1:1]     rr_pick;
    logic                  rr_valid;
    logic [PTR_W-1:0]      rr_win;
    logic [PTR_W-1:0]      rr_next;

    logic [3:0]            own_cmd;
    logic [BA_BITS-1:0]    own_ba;
    logic [ADDR_BITS-1:0]  own_addr;
    logic                  own_end;

    ddr2_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req    (ch_req[NUM_CH-1:1]),
        .rr_ptr (rr_ptr_q),
        .pick   (rr_pick),
        .valid  (rr_valid)
    );

    always_comb begin
        rr_win = PTR_FIRST;
        for (int i = 1; i < NUM_CH; i++) begin
            if (rr_pick[i]) begin
                rr_win = PTR_W'(i);
            end
        end
        rr_next = (rr_win == PTR_LAST) ? PTR_FIRST
                                       : rr_win + PTR_FIRST;
    end

    // Current owner's bundle, selected by the one-hot grant.
    always_comb begin
        own_cmd  = CMD_NOP;
        own_ba   = '0;
        own_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_q[i]) begin
                own_cmd  = ch_cmd[4*i +: 4];
                own_ba   = ch_ba[BA_BITS*i +: BA_BITS];
                own_addr = ch_addr[ADDR_BITS*i +: ADDR_BITS];
            end
        end
        own_end = |(ch_end & gnt_q);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        cmd_d      = cmd_q;
        ba_d       = ba_q;
        addr_d     = addr_q;
        cke_d      = init_cke;
        err_d      = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                if (init_end) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NOP;
                end else begin
                    cmd_d  = init_cmd;
                    ba_d   = init_ba;
                    addr_d = init_addr;
                end
            end
            ST_IDLE: begin
                cmd_d = CMD_NOP;
                if (ch_req[0]) begin
                    state_d    = ST_BUSY;
                    gnt_d      = NUM_CH'(1);
                    hold_cnt_d = '0;
                end else if (rr_valid) begin
                    state_d    = ST_BUSY;
                    gnt_d      = {rr_pick, 1'b0};
                    rr_ptr_d   = rr_next;
                    hold_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (own_end) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cmd_d   = CMD_NOP;
                end else begin
                    cmd_d  = own_cmd;
                    ba_d   = own_ba;
                    addr_d = own_addr;
                end
                // Saturating at HOLD_MAX makes the error a single pulse.
                err_d = (hold_cnt_q == CNT_ERR);
                if (hold_cnt_q != CNT_SAT) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                gnt_d   = '0;
                cmd_d   = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            gnt_q      <= '0;
            rr_ptr_q   <= PTR_FIRST;
            hold_cnt_q <= '0;
            cmd_q      <= CMD_NOP;
            ba_q       <= '0;
            addr_q     <= '0;
            cke_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            cke_q      <= cke_d;
            err_q      <= err_d;
        end
    end

    assign ch_gnt     = gnt_q;
    assign ddr2_cke   = cke_q;
    assign ddr2_cs_n  = cmd_q[3];
    assign ddr2_ras_n = cmd_q[2];
    assign ddr2_cas_n = cmd_q[1];
    assign ddr2_we_n  = cmd_q[0];
    assign ddr2_ba    = ba_q;
    assign ddr2_addr  = addr_q;
    assign err_hold   = err_q;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Bench for ddr2_cmd_arbiter: vector table for init/priority plus
// sequences for hold timeout, async reset and round-robin order.
module tb_ddr2_cmd_arbiter;
    import ddr2_pkg::*;

    logic        ck;
    logic        rst_n;
    logic        init_cke;
    logic [3:0]  init_cmd;
    logic [2:0]  init_ba;
    logic [12:0] init_addr;
    logic        init_end;
    logic [3:0]  ch_req;
    logic [3:0]  ch_end;
    logic [15:0] ch_cmd;
    logic [11:0] ch_ba;
    logic [51:0] ch_addr;
    logic [3:0]  ch_gnt;
    logic        ddr2_cke;
    logic        ddr2_cs_n;
    logic        ddr2_ras_n;
    logic        ddr2_cas_n;
    logic        ddr2_we_n;
    logic [2:0]  ddr2_ba;
    logic [12:0] ddr2_addr;
    logic        err_hold;

    typedef struct {
        int          ph;
        int          step;
        logic        cke_i;
        logic [3:0]  icmd;
        logic [2:0]  iba;
        logic [12:0] iaddr;
        logic        iend;
        logic [3:0]  req;
        logic [3:0]  endv;
        logic [3:0]  gnt;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [12:0] addr;
        logic        cke;
        logic        err;
    } vec_t;

    vec_t  tbl[21];
    vec_t  sb[$];
    int    n_chk;
    int    n_err;
    string ph_name[5];

    ddr2_cmd_arbiter #(
        .ADDR_BITS (13),
        .BA_BITS   (3),
        .NUM_CH    (4),
        .HOLD_MAX  (8)
    ) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .init_cke   (init_cke),
        .init_cmd   (init_cmd),
        .init_ba    (init_ba),
        .init_addr  (init_addr),
        .init_end   (init_end),
        .ch_req     (ch_req),
        .ch_end     (ch_end),
        .ch_cmd     (ch_cmd),
        .ch_ba      (ch_ba),
        .ch_addr    (ch_addr),
        .ch_gnt     (ch_gnt),
        .ddr2_cke   (ddr2_cke),
        .ddr2_cs_n  (ddr2_cs_n),
        .ddr2_ras_n (ddr2_ras_n),
        .ddr2_cas_n (ddr2_cas_n),
        .ddr2_we_n  (ddr2_we_n),
        .ddr2_ba    (ddr2_ba),
        .ddr2_addr  (ddr2_addr),
        .err_hold   (err_hold)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic vec_t mk(
        input int ph, input int step,
        input logic cke_i, input logic [3:0] icmd,
        input logic [2:0] iba, input logic [12:0] iaddr,
        input logic iend, input logic [3:0] req,
        input logic [3:0] endv, input logic [3:0] gnt,
        input logic [3:0] cmd, input logic [2:0] ba,
        input logic [12:0] addr, input logic cke,
        input logic err);
        vec_t v;
        v.ph = ph;       v.step = step;
        v.cke_i = cke_i; v.icmd = icmd;
        v.iba = iba;     v.iaddr = iaddr;
        v.iend = iend;   v.req = req;
        v.endv = endv;   v.gnt = gnt;
        v.cmd = cmd;     v.ba = ba;
        v.addr = addr;   v.cke = cke;
        v.err = err;
        return v;
    endfunction

    task automatic check(input vec_t e);
        logic [3:0] act_cmd;
        act_cmd = {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n};
        n_chk++;
        if (ch_gnt !== e.gnt || act_cmd !== e.cmd ||
            ddr2_ba !== e.ba || ddr2_addr !== e.addr ||
            ddr2_cke !== e.cke || err_hold !== e.err) begin
            n_err++;
            $display("FAIL %s[%0d]: got gnt=%b cmd=%b ba=%0d addr=%h cke=%b err=%b, want gnt=%b cmd=%b ba=%0d addr=%h cke=%b err=%b",
                     ph_name[e.ph], e.step, ch_gnt, act_cmd,
                     ddr2_ba, ddr2_addr, ddr2_cke, err_hold,
                     e.gnt, e.cmd, e.ba, e.addr, e.cke, e.err);
        end
    endtask

    // Expected result is queued with the stimulus, checked after the edge.
    task automatic drive(input vec_t v);
        init_cke  = v.cke_i;
        init_cmd  = v.icmd;
        init_ba   = v.iba;
        init_addr = v.iaddr;
        init_end  = v.iend;
        ch_req    = v.req;
        ch_end    = v.endv;
        sb.push_back(v);
        @(negedge ck);
    endtask

    task automatic run(input int ph, input int step,
                       input logic [3:0] req, input logic [3:0] endv,
                       input logic [3:0] gnt, input logic [3:0] cmd,
                       input logic [2:0] ba, input logic [12:0] addr,
                       input logic err);
        drive(mk(ph, step, 1'b1, CMD_NOP, 3'd0, 13'h0, 1'b1,
                 req, endv, gnt, cmd, ba, addr, 1'b1, err));
    endtask

    always @(posedge ck) begin
        #1;
        if (sb.size() != 0) begin
            check(sb.pop_front());
        end
    end

    initial begin
        logic [3:0]  chc[4];
        int          order[5];
        logic [2:0]  last_ba;
        logic [12:0] last_addr;
        logic [3:0]  oh;
        logic [2:0]  oba;
        logic [12:0] oaddr;
        int          o;

        n_chk = 0;
        n_err = 0;
        ph_name[0] = "tbl";
        ph_name[1] = "hold";
        ph_name[2] = "reinit";
        ph_name[3] = "rr";
        ph_name[4] = "reset";
        chc[0] = CMD_AREF;
        chc[1] = CMD_ACT;
        chc[2] = CMD_WR;
        chc[3] = CMD_RD;
        order[0] = 1; order[1] = 2; order[2] = 3;
        order[3] = 1; order[4] = 2;

        ch_cmd  = {CMD_RD, CMD_WR, CMD_ACT, CMD_AREF};
        ch_ba   = {3'd7, 3'd6, 3'd5, 3'd4};
        ch_addr = {13'h103, 13'h102, 13'h101, 13'h100};

        // ph step cke icmd ba addr end | req end | gnt cmd ba addr cke err
        tbl[0]  = mk(0, 0, 1, CMD_NOP, 0, 13'h000, 0, 4'b0000, 4'b0000,
                     4'b0000, CMD_NOP, 0, 13'h000, 1, 0);
        tbl[1]  = mk(0, 1, 1, CMD_PRE, 0, 13'h400, 0, 4'b1111, 4'b0000,
                     4'b0000, CMD_PRE, 0, 13'h400, 1, 0);
        tbl[2]  = mk(0, 2, 1, CMD_MRS, 2, 13'h000, 0, 4'b1111, 4'b0001,
                     4'b0000, CMD_MRS, 2, 13'h000, 1, 0);
        tbl[3]  = mk(0, 3, 1, CMD_MRS, 0, 13'h532, 0, 4'b1111, 4'b0000,
                     4'b0000, CMD_MRS, 0, 13'h532, 1, 0);
        tbl[4]  = mk(0, 4, 1, CMD_PRE, 1, 13'h400, 0, 4'b1111, 4'b0000,
                     4'b0000, CMD_PRE, 1, 13'h400, 1, 0);
        tbl[5]  = mk(0, 5, 1, CMD_MRS, 3, 13'h007, 1, 4'b0000, 4'b0000,
                     4'b0000, CMD_NOP, 1, 13'h400, 1, 0);
        tbl[6]  = mk(0, 6, 1, CMD_NOP, 0, 13'h000, 1, 4'b0111, 4'b0000,
                     4'b0001, CMD_NOP, 1, 13'h400, 1, 0);
        tbl[7]  = mk(0, 7, 1, CMD_NOP, 0, 13'h000, 1, 4'b0111, 4'b0000,
                     4'b0001, CMD_AREF, 4, 13'h100, 1, 0);
        tbl[8]  = mk(0, 8, 1, CMD_NOP, 0, 13'h000, 1, 4'b0110, 4'b0001,
                     4'b0000, CMD_NOP, 4, 13'h100, 1, 0);
        tbl[9]  = mk(0, 9, 1, CMD_NOP, 0, 13'h000, 1, 4'b0110, 4'b0000,
                     4'b0010, CMD_NOP, 4, 13'h100, 1, 0);
        tbl[10] = mk(0, 10, 1, CMD_NOP, 0, 13'h000, 1, 4'b0110, 4'b0100,
                     4'b0010, CMD_ACT, 5, 13'h101, 1, 0);
        tbl[11] = mk(0, 11, 1, CMD_NOP, 0, 13'h000, 1, 4'b0110, 4'b0010,
                     4'b0000, CMD_NOP, 5, 13'h101, 1, 0);
        tbl[12] = mk(0, 12, 1, CMD_NOP, 0, 13'h000, 1, 4'b0110, 4'b0000,
                     4'b0100, CMD_NOP, 5, 13'h101, 1, 0);
        tbl[13] = mk(0, 13, 1, CMD_NOP, 0, 13'h000, 1, 4'b0111, 4'b0000,
                     4'b0100, CMD_WR, 6, 13'h102, 1, 0);
        tbl[14] = mk(0, 14, 1, CMD_NOP, 0, 13'h000, 1, 4'b0111, 4'b0001,
                     4'b0100, CMD_WR, 6, 13'h102, 1, 0);
        tbl[15] = mk(0, 15, 1, CMD_NOP, 0, 13'h000, 1, 4'b0111, 4'b0100,
                     4'b0000, CMD_NOP, 6, 13'h102, 1, 0);
        tbl[16] = mk(0, 16, 1, CMD_NOP, 0, 13'h000, 1, 4'b0111, 4'b0000,
                     4'b0001, CMD_NOP, 6, 13'h102, 1, 0);
        tbl[17] = mk(0, 17, 1, CMD_NOP, 0, 13'h000, 1, 4'b0110, 4'b0001,
                     4'b0000, CMD_NOP, 6, 13'h102, 1, 0);
        tbl[18] = mk(0, 18, 0, CMD_NOP, 0, 13'h000, 0, 4'b0000, 4'b0000,
                     4'b0000, CMD_NOP, 6, 13'h102, 0, 0);
        tbl[19] = mk(0, 19, 1, CMD_NOP, 0, 13'h000, 0, 4'b1000, 4'b0000,
                     4'b1000, CMD_NOP, 6, 13'h102, 1, 0);
        tbl[20] = mk(0, 20, 1, CMD_NOP, 0, 13'h000, 0, 4'b0000, 4'b1000,
                     4'b0000, CMD_NOP, 6, 13'h102, 1, 0);

        rst_n     = 1'b0;
        init_cke  = 1'b0;
        init_cmd  = CMD_NOP;
        init_ba   = 3'd0;
        init_addr = 13'h0;
        init_end  = 1'b0;
        ch_req    = 4'b0000;
        ch_end    = 4'b0000;
        repeat (2) @(negedge ck);
        check(mk(4, 0, 0, CMD_NOP, 0, 0, 0, 0, 0,
                 4'b0000, CMD_NOP, 0, 13'h0, 0, 0));

        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i]);
        end

        // rr_ptr wrapped to 1 after ch3; ch1 is granted and never ends.
        run(1, 0, 4'b0010, 4'b0000, 4'b0010, CMD_NOP,
            3'd6, 13'h102, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            run(1, k, 4'b0010, 4'b0000, 4'b0010, CMD_ACT,
                3'd5, 13'h101, k == 8);
        end

        #2;
        rst_n  = 1'b0;
        ch_req = 4'b1111;
        #1;
        check(mk(4, 1, 0, CMD_NOP, 0, 0, 0, 0, 0,
                 4'b0000, CMD_NOP, 0, 13'h0, 0, 0));
        @(negedge ck);
        check(mk(4, 2, 0, CMD_NOP, 0, 0, 0, 0, 0,
                 4'b0000, CMD_NOP, 0, 13'h0, 0, 0));

        rst_n = 1'b1;
        drive(mk(2, 0, 1, CMD_NOP, 0, 13'h000, 0, 4'b1110, 4'b0000,
                 4'b0000, CMD_NOP, 0, 13'h000, 1, 0));
        drive(mk(2, 1, 1, CMD_MRS, 0, 13'h042, 0, 4'b1110, 4'b0010,
                 4'b0000, CMD_MRS, 0, 13'h042, 1, 0));
        drive(mk(2, 2, 1, CMD_PRE, 1, 13'h400, 1, 4'b1110, 4'b0000,
                 4'b0000, CMD_NOP, 0, 13'h042, 1, 0));

        last_ba   = 3'd0;
        last_addr = 13'h042;
        for (int n = 0; n < 5; n++) begin
            o     = order[n];
            oh    = 4'(1 << o);
            oba   = 3'(4 + o);
            oaddr = 13'(13'h100 + o);
            run(3, 4*n, 4'b1110, 4'b0000, oh, CMD_NOP,
                last_ba, last_addr, 1'b0);
            run(3, 4*n+1, 4'b1110, 4'b0000, oh, chc[o],
                oba, oaddr, 1'b0);
            run(3, 4*n+2, 4'b1110, 4'b0000, oh, chc[o],
                oba, oaddr, 1'b0);
            run(3, 4*n+3, 4'b1110, oh, 4'b0000, CMD_NOP,
                oba, oaddr, 1'b0);
            last_ba   = oba;
            last_addr = oaddr;
        end

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
